// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//
// Parametrised serial pattern detector. A free-running divider produces a
// sample tick every DIV clocks. On each tick the input bit x is shifted into
// a history register, and the longest pattern prefix that ends at the newest
// sample becomes the detection progress (prefix/suffix fallback, so a mismatch
// does not necessarily restart from zero). A complete match pulses `match`
// for one tick period and bumps a saturating match counter. The pattern can
// be reloaded at run time; overlap mode selects whether samples belonging to
// a completed match may start the next one.
//
// Parameters
//   PAT_LEN  pattern length in bits (2..8)
//   PATTERN  pattern after reset, MSB is the first bit expected
//   DIV      clock cycles per sample tick (>= 2)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   x          in   serial data bit, sampled on tick cycles only
//   ovl        in   1 = overlapping detection, 0 = non-overlapping
//   load_en    in   one-cycle strobe, loads load_pat and clears detection state
//   load_pat   in   new pattern, MSB first
//   match      out  high for the tick period following a complete match
//   match_cnt  out  number of matches, saturating at 255
//   progress   out  pattern bits currently matched, 0..PAT_LEN
//   seg        out  active-low 7-segment {a,b,c,d,e,f,g} showing progress
// -----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b0010,
    parameter int                 DIV     = 20000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               ovl,
    input  logic               load_en,
    input  logic [PAT_LEN-1:0] load_pat,
    output logic               match,
    output logic [7:0]         match_cnt,
    output logic [3:0]         progress,
    output logic [6:0]         seg
);

    localparam int                 DIV_W    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [3:0]         LEN4     = 4'(PAT_LEN);

    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [PAT_LEN-1:0] pat;
    logic [PAT_LEN-1:0] hist;
    logic [3:0]         nval;

    logic [PAT_LEN-1:0] h_next;
    logic [3:0]         n_next;
    logic [3:0]         k;
    logic [PAT_LEN-1:0] mask;
    logic               hit;

    // Saturating 8-bit increment for the match counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Active-low 7-segment decode, {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg_of(input logic [3:0] p);
        case (p)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign tick = (div_cnt == DIV_LAST);

    // Candidate history/valid count for this tick, and the longest pattern
    // prefix matching the newest samples. The loop runs upward so the last
    // hit wins, giving the largest k. k is bounded by n_next so samples that
    // predate a reset, load or non-overlapping match never contribute.
    always_comb begin
        h_next = PAT_LEN'({hist, x});
        n_next = (nval >= LEN4) ? LEN4 : nval + 4'd1;
        k      = 4'd0;
        mask   = '0;
        for (int kk = 1; kk <= PAT_LEN; kk++) begin
            // Low kk bits of the mask set; pat shifted so its top kk bits
            // line up with the kk newest history bits.
            mask = {PAT_LEN{1'b1}} >> (PAT_LEN - kk);
            if ((kk <= int'(n_next)) &&
                (((h_next ^ (pat >> (PAT_LEN - kk))) & mask) == '0)) begin
                k = 4'(kk);
            end
        end
        hit = (k == LEN4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            pat       <= PATTERN;
            hist      <= '0;
            nval      <= '0;
            progress  <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            // The divider free-runs; a pattern load does not disturb it.
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);

            // A load takes priority over a coincident tick, dropping that sample.
            if (load_en) begin
                pat       <= load_pat;
                hist      <= '0;
                nval      <= '0;
                progress  <= '0;
                match     <= 1'b0;
                match_cnt <= '0;
            end else if (tick) begin
                hist     <= h_next;
                progress <= k;
                match    <= hit;
                if (hit) begin
                    match_cnt <= sat_inc8(match_cnt);
                end
                // Non-overlapping mode forgets every sample of the completed match.
                nval <= (hit && !ovl) ? 4'd0 : n_next;
            end
        end
    end

    assign seg = seg_of(progress);

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//
// Directed bench for seq_detector_param with DIV = 4. Three instances:
//   a : PAT_LEN 4, reset pattern 0010 (match, fallback, overlap, reset/load)
//   b : PAT_LEN 2, pattern 11          (counter saturation)
//   c : PAT_LEN 8, pattern 10110011    (full width)
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance a
    logic       rst_a = 1'b1, x_a = 1'b0, ovl_a = 1'b1, load_en_a = 1'b0;
    logic [3:0] load_pat_a = 4'b0000;
    logic       match_a;
    logic [7:0] cnt_a;
    logic [3:0] prog_a;
    logic [6:0] seg_a;

    // Instance b
    logic       rst_b = 1'b1, x_b = 1'b0, ovl_b = 1'b1, load_en_b = 1'b0;
    logic [1:0] load_pat_b = 2'b00;
    logic       match_b;
    logic [7:0] cnt_b;
    logic [3:0] prog_b;
    logic [6:0] seg_b;

    // Instance c
    logic       rst_c = 1'b1, x_c = 1'b0, ovl_c = 1'b1, load_en_c = 1'b0;
    logic [7:0] load_pat_c = 8'h00;
    logic       match_c;
    logic [7:0] cnt_c;
    logic [3:0] prog_c;
    logic [6:0] seg_c;

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b0010), .DIV(4)) dut_a (
        .clk(clk), .rst(rst_a), .x(x_a), .ovl(ovl_a), .load_en(load_en_a),
        .load_pat(load_pat_a), .match(match_a), .match_cnt(cnt_a),
        .progress(prog_a), .seg(seg_a)
    );

    seq_detector_param #(.PAT_LEN(2), .PATTERN(2'b11), .DIV(4)) dut_b (
        .clk(clk), .rst(rst_b), .x(x_b), .ovl(ovl_b), .load_en(load_en_b),
        .load_pat(load_pat_b), .match(match_b), .match_cnt(cnt_b),
        .progress(prog_b), .seg(seg_b)
    );

    seq_detector_param #(.PAT_LEN(8), .PATTERN(8'b10110011), .DIV(4)) dut_c (
        .clk(clk), .rst(rst_c), .x(x_c), .ovl(ovl_c), .load_en(load_en_c),
        .load_pat(load_pat_c), .match(match_c), .match_cnt(cnt_c),
        .progress(prog_c), .seg(seg_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one sample to a and advance to just after the tick that takes it.
    task automatic step_a(input logic v);
        x_a = v;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic step_c(input logic v);
        x_c = v;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Called just after a tick edge: strobes load_en for exactly the next tick cycle.
    task automatic load_a(input logic [3:0] p);
        load_pat_a = p;
        repeat (3) @(posedge clk);
        #1 load_en_a = 1'b1;
        @(posedge clk);
        #1 load_en_a = 1'b0;
    endtask

    task automatic expect_a(input string tag, input logic [3:0] p, input logic m, input logic [7:0] c);
        chk({tag, ".progress"}, 32'(prog_a), 32'(p));
        chk({tag, ".match"}, 32'(match_a), 32'(m));
        chk({tag, ".match_cnt"}, 32'(cnt_a), 32'(c));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        expect_a("reset_a", 4'd0, 1'b0, 8'd0);
        chk("reset_a.seg", 32'(seg_a), 32'(7'b0000001));
        chk("reset_c.seg", 32'(seg_c), 32'(7'b0000001));

        // ---------------- basic match: 0010, ovl=1 ----------------
        @(negedge clk) rst_a = 1'b0;
        step_a(1'b0); expect_a("basic1", 4'd1, 1'b0, 8'd0);
        chk("basic1.seg", 32'(seg_a), 32'(7'b1001111));
        step_a(1'b0); expect_a("basic2", 4'd2, 1'b0, 8'd0);
        chk("basic2.seg", 32'(seg_a), 32'(7'b0010010));
        step_a(1'b1); expect_a("basic3", 4'd3, 1'b0, 8'd0);
        chk("basic3.seg", 32'(seg_a), 32'(7'b0000110));
        step_a(1'b0); expect_a("basic4", 4'd4, 1'b1, 8'd1);
        chk("basic4.seg", 32'(seg_a), 32'(7'b1001100));
        // Results hold through the rest of the tick period.
        repeat (3) @(posedge clk);
        #1;
        expect_a("basic_hold", 4'd4, 1'b1, 8'd1);
        @(posedge clk);
        #1;

        // ---------------- fallback: 0,0,0,1,0 ----------------
        load_a(4'b0010);
        expect_a("load_clear", 4'd0, 1'b0, 8'd0);
        step_a(1'b0); expect_a("fb1", 4'd1, 1'b0, 8'd0);
        step_a(1'b0); expect_a("fb2", 4'd2, 1'b0, 8'd0);
        step_a(1'b0); expect_a("fb3", 4'd2, 1'b0, 8'd0);
        step_a(1'b1); expect_a("fb4", 4'd3, 1'b0, 8'd0);
        step_a(1'b0); expect_a("fb5", 4'd4, 1'b1, 8'd1);

        // ---------------- overlap: 0101, ovl=1 ----------------
        load_a(4'b0101);
        step_a(1'b0); expect_a("ov1", 4'd1, 1'b0, 8'd0);
        step_a(1'b1); expect_a("ov2", 4'd2, 1'b0, 8'd0);
        step_a(1'b0); expect_a("ov3", 4'd3, 1'b0, 8'd0);
        step_a(1'b1); expect_a("ov4", 4'd4, 1'b1, 8'd1);
        step_a(1'b0); expect_a("ov5", 4'd3, 1'b0, 8'd1);
        step_a(1'b1); expect_a("ov6", 4'd4, 1'b1, 8'd2);

        // ---------------- non-overlap: 0101, ovl=0 ----------------
        ovl_a = 1'b0;
        load_a(4'b0101);
        step_a(1'b0); expect_a("nov1", 4'd1, 1'b0, 8'd0);
        step_a(1'b1); expect_a("nov2", 4'd2, 1'b0, 8'd0);
        step_a(1'b0); expect_a("nov3", 4'd3, 1'b0, 8'd0);
        step_a(1'b1); expect_a("nov4", 4'd4, 1'b1, 8'd1);
        step_a(1'b0); expect_a("nov5", 4'd1, 1'b0, 8'd1);
        step_a(1'b1); expect_a("nov6", 4'd2, 1'b0, 8'd1);

        // ---------------- reset mid-period, then load on a tick ----------------
        load_a(4'b0010);
        step_a(1'b0); step_a(1'b0); step_a(1'b1); step_a(1'b0);
        expect_a("pre_rst_match", 4'd4, 1'b1, 8'd1);
        step_a(1'b0); step_a(1'b0); step_a(1'b1);
        expect_a("pre_rst", 4'd3, 1'b0, 8'd1);
        #2 rst_a = 1'b1;
        #1;
        expect_a("async_rst", 4'd0, 1'b0, 8'd0);
        chk("async_rst.seg", 32'(seg_a), 32'(7'b0000001));
        ovl_a = 1'b1;
        @(negedge clk) rst_a = 1'b0;
        // Fourth edge after release is a tick; load on it with x=1.
        x_a = 1'b1;
        load_pat_a = 4'b1000;
        repeat (3) @(posedge clk);
        #1 load_en_a = 1'b1;
        @(posedge clk);
        #1 load_en_a = 1'b0;
        expect_a("load_on_tick", 4'd0, 1'b0, 8'd0);
        step_a(1'b1); expect_a("after_load", 4'd1, 1'b0, 8'd0);
        step_a(1'b0); expect_a("after_load2", 4'd2, 1'b0, 8'd0);

        // ---------------- saturation: PAT_LEN 2, pattern 11, x=1 ----------------
        x_b = 1'b1;
        @(negedge clk) rst_b = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("sat_t1.progress", 32'(prog_b), 32'd1);
        chk("sat_t1.match", 32'(match_b), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("sat_t2.match", 32'(match_b), 32'd1);
        chk("sat_t2.match_cnt", 32'(cnt_b), 32'd1);
        repeat (4 * 253) @(posedge clk);
        #1;
        chk("sat_t255.match_cnt", 32'(cnt_b), 32'd254);
        repeat (4) @(posedge clk);
        #1;
        chk("sat_t256.match_cnt", 32'(cnt_b), 32'd255);
        repeat (4 * 45) @(posedge clk);
        #1;
        chk("sat_t301.match_cnt", 32'(cnt_b), 32'd255);
        chk("sat_t301.match", 32'(match_b), 32'd1);
        chk("sat_t301.progress", 32'(prog_b), 32'd2);

        // ---------------- width: PAT_LEN 8, pattern 10110011 ----------------
        @(negedge clk) rst_c = 1'b0;
        step_c(1'b1); chk("w1", 32'(prog_c), 32'd1);
        step_c(1'b0); chk("w2", 32'(prog_c), 32'd2);
        step_c(1'b1); chk("w3", 32'(prog_c), 32'd3);
        step_c(1'b1); chk("w4", 32'(prog_c), 32'd4);
        step_c(1'b0); chk("w5", 32'(prog_c), 32'd5);
        chk("w5.seg", 32'(seg_c), 32'(7'b0100100));
        step_c(1'b0); chk("w6", 32'(prog_c), 32'd6);
        chk("w6.seg", 32'(seg_c), 32'(7'b0100000));
        step_c(1'b1); chk("w7", 32'(prog_c), 32'd7);
        chk("w7.seg", 32'(seg_c), 32'(7'b0001111));
        chk("w7.match", 32'(match_c), 32'd0);
        step_c(1'b1); chk("w8", 32'(prog_c), 32'd8);
        chk("w8.seg", 32'(seg_c), 32'(7'b0000000));
        chk("w8.match", 32'(match_c), 32'd1);
        chk("w8.match_cnt", 32'(cnt_c), 32'd1);
        // History becomes ...0110 0110: the two newest samples "10" equal the
        // pattern's first two bits, so the longest-prefix rule yields 2.
        step_c(1'b0);
        chk("w9.progress", 32'(prog_c), 32'd2);
        chk("w9.match", 32'(match_c), 32'd0);
        chk("w9.seg", 32'(seg_c), 32'(7'b0010010));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
